// File: rtl/router_pkg.sv
// Shared constants for the ring router: default flit width, hop-field position
// and virtual-channel identifiers (VC index doubles as its internal polarity).
package router_pkg;
    localparam int   DATA_WIDTH_DEFAULT = 64;
    localparam int   HOP_MSB            = 55;
    localparam int   HOP_LSB            = 48;
    localparam logic VC_EVEN            = 1'b0;
    localparam logic VC_ODD             = 1'b1;
endpackage

// File: rtl/ring_out_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping, and moves the pointer past the winner when a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
        // Gating last keeps the search itself free of rst/en.
        if (rst || !en) begin
            grant = '0;
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/ring_out_arbiter.sv
// Per-output arbiter with one-flit buffer per VC; fills a VC on its internal
// phase and drains it on the opposite phase. Optional macro: ROUTER_HOP_SHIFT_EN.
module ring_out_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          polarity,
    input  logic [NUM_REQ-1:0]            req_even,
    input  logic [NUM_REQ-1:0]            req_odd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_even,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_odd,
    output logic [NUM_REQ-1:0]            grant_even,
    output logic [NUM_REQ-1:0]            grant_odd,
    output logic                          so,
    input  logic                          ro,
    output logic [DATA_WIDTH-1:0]         dout
);
    logic [DATA_WIDTH-1:0] buf_even_q, buf_even_d;
    logic [DATA_WIDTH-1:0] buf_odd_q, buf_odd_d;
    logic                  full_even_q, full_even_d;
    logic                  full_odd_q, full_odd_d;
    logic                  so_q, so_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] win_even, win_odd;
    logic [DATA_WIDTH-1:0] adj_even, adj_odd;
    logic                  en_even, en_odd;

    assign en_even = ~full_even_q & (polarity == VC_EVEN);
    assign en_odd  = ~full_odd_q  & (polarity == VC_ODD);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb_even (
        .clk   (clk),
        .rst   (rst),
        .en    (en_even),
        .req   (req_even),
        .grant (grant_even)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb_odd (
        .clk   (clk),
        .rst   (rst),
        .en    (en_odd),
        .req   (req_odd),
        .grant (grant_odd)
    );

    // Grants are one-hot, so OR-ing masked lanes selects the winner's flit.
    always_comb begin
        win_even = '0;
        win_odd  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_even[i]) win_even |= din_even[i*DATA_WIDTH +: DATA_WIDTH];
            if (grant_odd[i])  win_odd  |= din_odd[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        adj_even = win_even;
        adj_odd  = win_odd;
`ifdef ROUTER_HOP_SHIFT_EN
        adj_even[HOP_MSB:HOP_LSB] = win_even[HOP_MSB:HOP_LSB] >> 1;
        adj_odd[HOP_MSB:HOP_LSB]  = win_odd[HOP_MSB:HOP_LSB] >> 1;
`endif
    end

    // Fill and drain of one VC sit on opposite phases, so they never collide.
    always_comb begin
        buf_even_d  = buf_even_q;
        buf_odd_d   = buf_odd_q;
        full_even_d = full_even_q;
        full_odd_d  = full_odd_q;
        so_d        = 1'b0;
        dout_d      = dout_q;
        if (|grant_even) begin
            buf_even_d  = adj_even;
            full_even_d = 1'b1;
        end
        if (|grant_odd) begin
            buf_odd_d  = adj_odd;
            full_odd_d = 1'b1;
        end
        if ((polarity == VC_EVEN) && full_odd_q && ro) begin
            so_d       = 1'b1;
            dout_d     = buf_odd_q;
            full_odd_d = 1'b0;
        end
        if ((polarity == VC_ODD) && full_even_q && ro) begin
            so_d        = 1'b1;
            dout_d      = buf_even_q;
            full_even_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_even_q  <= '0;
            buf_odd_q   <= '0;
            full_even_q <= 1'b0;
            full_odd_q  <= 1'b0;
            so_q        <= 1'b0;
            dout_q      <= '0;
        end else begin
            buf_even_q  <= buf_even_d;
            buf_odd_q   <= buf_odd_d;
            full_even_q <= full_even_d;
            full_odd_q  <= full_odd_d;
            so_q        <= so_d;
            dout_q      <= dout_d;
        end
    end

    assign so   = so_q;
    assign dout = dout_q;
endmodule
